// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC cores: binary-angle atan table (2^32 = 360 deg),
// angle constants, the 1/K gain constant and the controller state encoding.
package cordic_pkg;

  localparam logic [31:0] ANG_90  = 32'h4000_0000;
  localparam logic [31:0] ANG_180 = 32'h8000_0000;

  // 1/K as a Q15 fraction; only its set bits become adders
  localparam logic [15:0] KINV      = 16'h4DBA;
  localparam int          KINV_FRAC = 15;

  typedef logic [1:0] cordic_state_t;
  localparam cordic_state_t ST_IDLE   = 2'd0;
  localparam cordic_state_t ST_ROTATE = 2'd1;
  localparam cordic_state_t ST_DONE   = 2'd2;

  function automatic logic [31:0] atan_lut(input logic [3:0] idx);
    logic [31:0] v;
    case (idx)
      4'd0:    v = 32'h2000_0000;
      4'd1:    v = 32'h12E4_051E;
      4'd2:    v = 32'h09FB_385B;
      4'd3:    v = 32'h0511_11D4;
      4'd4:    v = 32'h028B_0D43;
      4'd5:    v = 32'h0145_D7E1;
      4'd6:    v = 32'h00A2_F61E;
      4'd7:    v = 32'h0051_7C55;
      4'd8:    v = 32'h0028_BE53;
      4'd9:    v = 32'h0014_5F2F;
      4'd10:   v = 32'h000A_2F98;
      4'd11:   v = 32'h0005_17CC;
      4'd12:   v = 32'h0002_8BE6;
      4'd13:   v = 32'h0001_45F3;
      4'd14:   v = 32'h0000_A2FA;
      default: v = 32'h0000_517D;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring micro-rotation: drives y toward zero and accumulates the turned angle in z.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int XW = 18
) (
  input  logic signed [XW-1:0] x_cur,
  input  logic signed [XW-1:0] y_cur,
  input  logic        [31:0]   z_cur,
  input  logic        [3:0]    idx,
  output logic signed [XW-1:0] x_nxt,
  output logic signed [XW-1:0] y_nxt,
  output logic        [31:0]   z_nxt
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic        [31:0]   ang;

  assign x_sh = x_cur >>> idx;
  assign y_sh = y_cur >>> idx;
  assign ang  = atan_lut(idx);

  always_comb begin
    if (!y_cur[XW-1]) begin
      x_nxt = x_cur + y_sh;
      y_nxt = y_cur - x_sh;
      z_nxt = z_cur + ang;
    end else begin
      x_nxt = x_cur - y_sh;
      y_nxt = y_cur + x_sh;
      z_nxt = z_cur - ang;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: signed (x, y) -> magnitude and atan2 angle, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to scale the magnitude by 1/K; otherwise it carries the ~1.647 CORDIC gain.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ANGLE_WIDTH = 32,
  parameter int ITER        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH:0]          mag_out,
  output logic [ANGLE_WIDTH-1:0]  angle_out
);

  localparam int         XW       = WIDTH + 2;
  localparam logic [3:0] LAST_IDX = 4'(ITER - 1);

  cordic_state_t          state_reg;
  logic [3:0]             iter_reg;
  logic signed [XW-1:0]   x_reg, y_reg;
  logic [31:0]            z_reg;
  logic                   zero_reg;
  logic                   busy_reg, done_reg;
  logic [WIDTH:0]         mag_reg;
  logic [ANGLE_WIDTH-1:0] angle_reg;

  logic signed [XW-1:0]   x_ext, y_ext, x_next, y_next;
  logic [31:0]            z_next;
  logic [XW-1:0]          x_u;
  logic [WIDTH:0]         mag_next;

  assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};
  assign x_u   = x_reg;

  cordic_vec_stage #(.XW(XW)) u_stage (
    .x_cur (x_reg),
    .y_cur (y_reg),
    .z_cur (z_reg),
    .idx   (iter_reg),
    .x_nxt (x_next),
    .y_nxt (y_next),
    .z_nxt (z_next)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = XW + 16;
  logic [PW-1:0] pp [16];
  logic [PW-1:0] prod;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_kinv
      assign pp[gi] = KINV[gi] ? (PW'(x_u) << gi) : '0;
    end
  endgenerate

  always_comb begin
    prod = '0;
    for (int k = 0; k < 16; k++) prod = prod + pp[k];
  end
  assign mag_next = prod[KINV_FRAC +: WIDTH+1];
`else
  // x stays non-negative after the load, so its low bits are the magnitude
  assign mag_next = x_u[WIDTH:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      iter_reg  <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      zero_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      mag_reg   <= '0;
      angle_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            // Left half-plane: pre-rotate by 180 deg so the iterations converge
            if (x_in[WIDTH-1]) begin
              x_reg <= -x_ext;
              y_reg <= -y_ext;
              z_reg <= ANG_180;
            end else begin
              x_reg <= x_ext;
              y_reg <= y_ext;
              z_reg <= '0;
            end
            zero_reg  <= (x_in == '0) && (y_in == '0);
            iter_reg  <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_ROTATE;
          end else if (done_reg) begin
            busy_reg <= 1'b0;
          end
        end
        ST_ROTATE: begin
          x_reg    <= x_next;
          y_reg    <= y_next;
          z_reg    <= z_next;
          iter_reg <= iter_reg + 4'd1;
          if (iter_reg == LAST_IDX) state_reg <= ST_DONE;
        end
        ST_DONE: begin
          // A zero vector has no direction; report 0 rather than the summed table
          mag_reg   <= mag_next;
          angle_reg <= zero_reg ? '0 : ANGLE_WIDTH'(z_reg);
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign mag_out   = mag_reg;
  assign angle_out = angle_reg;

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative vectoring-mode CORDIC. It is the inverse of the existing rotation-mode CORDIC: instead of turning an angle into cos/sin, it turns a signed (x, y) vector into a magnitude and an angle (atan2). It uses the same 32-bit binary angle format as the rotation core, where 2^32 = 360°. It processes one micro-rotation per clock behind a start/busy/done handshake, so a rotation core's outputs can be fed back through it for round-trip checking.

## Interface
- WIDTH, 16, bit width of signed x_in/y_in
- ANGLE_WIDTH, 32, binary angle width; fixed at 32 by the atan table
- ITER, 16, number of micro-rotations; legal range 1..16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- x_in  input  WIDTH  signed two's-complement x; captured on the accepted start
- y_in  input  WIDTH  signed two's-complement y; captured on the accepted start
- busy  output  1  high from the cycle after an accepted start through the done cycle
- done  output  1  one-cycle pulse; results valid from this cycle onward
- mag_out  output  WIDTH+1  unsigned magnitude; held until the next done
- angle_out  output  ANGLE_WIDTH  atan2(y, x) in binary-angle units, modulo 2^32; held until the next done

## Operation
- States:
  - IDLE: start=1 → ROTATE.
  - ROTATE: leaves after ITER iterations → DONE.
  - DONE: unconditional → IDLE.
- Load, on the edge where start is accepted in IDLE:
  - Sign-extend x and y to WIDTH+2 bits.
  - If x_in < 0: x = -x_in, y = -y_in, z = 0x8000_0000.
  - Otherwise: x = x_in, y = y_in, z = 0.
  - Set iteration counter i = 0.
- ROTATE, one iteration per clock:
  - If y ≥ 0: x += y>>>i, y -= x>>>i, z += ATAN[i].
  - Otherwise: x -= y>>>i, y += x>>>i, z -= ATAN[i].
  - The right-hand sides use pre-update values; shifts are arithmetic.
  - z arithmetic wraps modulo 2^32.
- DONE: register mag_out and angle_out = z, pulse done.
- Magnitude:
  - Without compensation, mag_out = x ≈ 1.647·√(x²+y²).
  - x never exceeds 1.647·√2·2^(WIDTH-1) < 2^(WIDTH+1), so the WIDTH+2 signed internal width never overflows.
- start in ROTATE or DONE is ignored and not queued.
- x_in = y_in = 0 gives mag_out = 0, angle_out = 0.
- x_in = -2^(WIDTH-1) is legal: the negation happens after sign extension.
- Reset mid-operation: the state machine returns to IDLE, the computation is discarded, and all outputs clear.

## Timing
- Reset values: busy=0, done=0, mag_out=0, angle_out=0, state IDLE.
- If start is accepted at edge N:
  - busy rises after edge N.
  - The iterations execute on edges N+1 … N+ITER.
  - done and new results appear after edge N+ITER+1.
  - Latency from accepted start to done is ITER+1 cycles; ITER=16 gives 17.
- busy falls after edge N+ITER+2, together with done.
- Earliest next accepted start is at edge N+ITER+2, giving a throughput of one result per ITER+2 cycles.
- Outputs change only on the done edge.

## Configuration
- CORDIC_GAIN_COMP_EN:
  - Defined: the DONE-state magnitude is multiplied by 1/K ≈ 0x4DBA/2^15 (0.60725) using a fixed shift-add constant. mag_out = √(x²+y²) truncated, ±2 LSB. Latency is unchanged; the multiply is combinational inside the DONE cycle.
  - Undefined: mag_out carries the raw CORDIC gain (≈1.647×).
- angle_out is identical in both builds.

## Structure
- Shared package cordic_pkg holds:
  - the ATAN table of 16 × 32-bit entries:
    - i0–i3: 0x2000_0000, 0x12E4_051E, 0x09FB_385B, 0x0511_11D4
    - i4–i7: 0x028B_0D43, 0x0145_D7E1, 0x00A2_F61E, 0x0051_7C55
    - i8–i11: 0x0028_BE53, 0x0014_5F2F, 0x000A_2F98, 0x0005_17CC
    - i12–i15: 0x0002_8BE6, 0x0001_45F3, 0x0000_A2FA, 0x0000_517D
  - the angle constants ANG_90 = 0x4000_0000 and ANG_180 = 0x8000_0000;
  - the 1/K constant 0x4DBA;
  - the state enum.
- The rotation core imports the same package.
- One natural sub-module, cordic_vec_stage: the combinational single micro-rotation (x, y, z, i → x', y', z'), reused each cycle.

## Test plan
Angle tolerance is ±0x0010_0000 for all angle checks below.
- (16000, 0): angle_out = 0; mag_out = 26352±4 uncompensated, 16000±2 compensated; done exactly 17 cycles after start.
- (1000, 1000): angle_out = 0x2000_0000 (45°); mag_out = 1414±2 compensated.
- (0, 8000): angle_out = 0x4000_0000.
- (0, -8000): angle_out = 0xC000_0000.
- (-8000, 0): angle_out = 0x8000_0000.
- (-32768, -32768): angle_out = 0xA000_0000, mag_out in range.
- start re-pulsed at cycles 3 and 17 after an accepted start is ignored, with exactly one done. rst_n asserted at iteration 8 clears all outputs, and the next start completes normally.
